// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic light monitor.
// Contents: light code constants, monitor state enum, phase order and
// expected-duration helpers.
package traffic_pkg;

  localparam logic [1:0] RED     = 2'b00;
  localparam logic [1:0] YELLOW  = 2'b01;
  localparam logic [1:0] GREEN   = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  typedef enum logic {SYNC, TRACK} mon_state_e;

  // Legal successor of a phase; ILLEGAL has no successor.
  function automatic logic [1:0] next_light(input logic [1:0] code);
    case (code)
      RED:     next_light = GREEN;
      GREEN:   next_light = YELLOW;
      YELLOW:  next_light = RED;
      default: next_light = ILLEGAL;
    endcase
  endfunction

  // Expected dwell of a phase; ILLEGAL has none.
  function automatic int expected_cyc(input logic [1:0] code,
                                      input int red_cyc,
                                      input int green_cyc,
                                      input int yel_cyc);
    case (code)
      RED:     expected_cyc = red_cyc;
      GREEN:   expected_cyc = green_cyc;
      YELLOW:  expected_cyc = yel_cyc;
      default: expected_cyc = 0;
    endcase
  endfunction

endpackage

// File: rtl/tlm_dwell_counter.sv
// tlm_dwell_counter: CNT_W saturating up-counter with a load-to-1 on clear.
// Ports: clk, reset (async, active-high), load_i (restart at 1),
//        cnt_o (registered count), cnt_d_o (next count), sat_hit_o (count reaches max this edge).
module tlm_dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_d_o,
  output logic             sat_hit_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_PRE = {{(CNT_W-1){1'b1}}, 1'b0};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires only on the single edge that moves the count onto the max value.
  assign sat_hit_o = !load_i && (cnt_q == CNT_PRE);
  assign cnt_o     = cnt_q;
  assign cnt_d_o   = cnt_d;

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: receive-side checker for the 2-bit light code.
// Ports: clk, reset (async, active-high), light in; phase, dwell, remaining,
//        locked, code_err, seq_err, dur_err, cycle_done out (all registered).
// Build option: TLM_STICKY_ERR_EN makes error flags latch until reset and blocks cycle_done.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int RED_CYC   = 30,
  parameter int GREEN_CYC = 90,
  parameter int YEL_CYC   = 5,
  parameter int TOL       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       light,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic [CNT_W-1:0] remaining,
  output logic             locked,
  output logic             code_err,
  output logic             seq_err,
  output logic             dur_err,
  output logic             cycle_done
);

  logic [1:0]       light_q;
  mon_state_e       state_q, state_d;
  logic             locked_q, locked_d;
  logic             code_err_q, code_err_d;
  logic             seq_err_q, seq_err_d;
  logic             dur_err_q, dur_err_d;
  logic             cycle_done_q, cycle_done_d;
  logic             cycle_ok_q, cycle_ok_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             sat_hit;
  logic             change;
  logic             code_now, seq_now, dur_now, done_now, any_err;
  int               meas_diff;
  int               exp_new;

  assign change = (light != light_q);

  tlm_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk       (clk),
    .reset     (reset),
    .load_i    (change),
    .cnt_o     (dwell_q),
    .cnt_d_o   (dwell_d),
    .sat_hit_o (sat_hit)
  );

  always_comb begin
    state_d      = state_q;
    locked_d     = locked_q;
    code_now     = 1'b0;
    seq_now      = 1'b0;
    dur_now      = 1'b0;
    done_now     = 1'b0;
    meas_diff    = 0;
    exp_new      = 0;
    remaining_d  = '0;

    if (change && light == ILLEGAL) begin
      // Illegal code wins: drop lock and skip order/duration checks.
      code_now = 1'b1;
      state_d  = SYNC;
      locked_d = 1'b0;
    end else if (change) begin
      if (state_q == SYNC) begin
        // First phase seen is partial, so only lock here; leaving 11 is not a legal boundary.
        if (light_q != ILLEGAL) begin
          state_d  = TRACK;
          locked_d = 1'b1;
        end
      end else begin
        seq_now   = (light != next_light(light_q));
        meas_diff = int'(dwell_q) - expected_cyc(light_q, RED_CYC, GREEN_CYC, YEL_CYC);
        dur_now   = (meas_diff > TOL) || (meas_diff < -TOL);
      end
    end else if (state_q == TRACK && sat_hit) begin
      dur_now = 1'b1;
    end

    any_err = code_now | seq_now | dur_now;

    done_now = change && (light == RED) && (light_q == YELLOW) &&
               (state_q == TRACK) && cycle_ok_q && !any_err;

    // Error clears the cycle; a clean RED entry starts a fresh one.
    if (any_err) begin
      cycle_ok_d = 1'b0;
    end else if (change && light == RED) begin
      cycle_ok_d = 1'b1;
    end else begin
      cycle_ok_d = cycle_ok_q;
    end

`ifdef TLM_STICKY_ERR_EN
    code_err_d   = code_err_q | code_now;
    seq_err_d    = seq_err_q  | seq_now;
    dur_err_d    = dur_err_q  | dur_now;
    cycle_done_d = done_now & ~(code_err_d | seq_err_d | dur_err_d);
`else
    code_err_d   = code_now;
    seq_err_d    = seq_now;
    dur_err_d    = dur_now;
    cycle_done_d = done_now;
`endif

    // Computed from next-state values so it lines up with the registered dwell.
    exp_new = expected_cyc(light, RED_CYC, GREEN_CYC, YEL_CYC);
    if (locked_d && int'(dwell_d) < exp_new) begin
      remaining_d = CNT_W'(exp_new - int'(dwell_d));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      light_q      <= RED;
      state_q      <= SYNC;
      locked_q     <= 1'b0;
      code_err_q   <= 1'b0;
      seq_err_q    <= 1'b0;
      dur_err_q    <= 1'b0;
      cycle_done_q <= 1'b0;
      cycle_ok_q   <= 1'b1;
      remaining_q  <= '0;
    end else begin
      light_q      <= light;
      state_q      <= state_d;
      locked_q     <= locked_d;
      code_err_q   <= code_err_d;
      seq_err_q    <= seq_err_d;
      dur_err_q    <= dur_err_d;
      cycle_done_q <= cycle_done_d;
      cycle_ok_q   <= cycle_ok_d;
      remaining_q  <= remaining_d;
    end
  end

  assign phase      = light_q;
  assign dwell      = dwell_q;
  assign remaining  = remaining_q;
  assign locked     = locked_q;
  assign code_err   = code_err_q;
  assign seq_err    = seq_err_q;
  assign dur_err    = dur_err_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: scoreboard bench for traffic_light_monitor.
// Each phase entry pushes its expected outputs; the observed entry is queued
// beside it and each scenario task pops and compares the pairs.
module tb_traffic_light_monitor;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;
  localparam logic [1:0] X = 2'b11;

  typedef struct packed {
    logic [1:0] ph;
    logic [7:0] dw;
    logic [7:0] rem;
    logic       lck;
    logic       ce;
    logic       se;
    logic       de;
    logic       cd;
    logic [2:0] hold_flags;
    logic       hold_cd;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] light;
  logic [1:0] phase;
  logic [7:0] dwell;
  logic [7:0] remaining;
  logic       locked, code_err, seq_err, dur_err, cycle_done;

  int   checks   = 0;
  int   failures = 0;
  ent_t exp_q[$];
  ent_t obs_q[$];

  traffic_light_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .light      (light),
    .phase      (phase),
    .dwell      (dwell),
    .remaining  (remaining),
    .locked     (locked),
    .code_err   (code_err),
    .seq_err    (seq_err),
    .dur_err    (dur_err),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  // Expected entry-cycle outputs; dwell is 1 on the first cycle of every phase.
  function automatic ent_t mk(input logic [1:0] ph, input logic [7:0] rem,
                              input logic lck, input logic ce, input logic se,
                              input logic de, input logic cd);
    ent_t e;
    e.ph  = ph;
    e.dw  = 8'd1;
    e.rem = rem;
    e.lck = lck;
    e.ce  = ce;
    e.se  = se;
    e.de  = de;
    e.cd  = cd;
`ifdef TLM_STICKY_ERR_EN
    e.hold_flags = {ce, se, de};
`else
    e.hold_flags = 3'b000;
`endif
    e.hold_cd = 1'b0;
    return e;
  endfunction

  // Hold a code for n sampled cycles; records the entry cycle and ORs later flags.
  task automatic drive_phase(input logic [1:0] code, input int n, input ent_t e);
    ent_t o;
    @(negedge clk);
    light = code;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o.ph = phase; o.dw = dwell; o.rem = remaining; o.lck = locked;
    o.ce = code_err; o.se = seq_err; o.de = dur_err; o.cd = cycle_done;
    o.hold_flags = 3'b000;
    o.hold_cd    = 1'b0;
    for (int i = 1; i < n; i++) begin
      @(posedge clk);
      #1;
      o.hold_flags = o.hold_flags | {code_err, seq_err, dur_err};
      o.hold_cd    = o.hold_cd | cycle_done;
    end
    obs_q.push_back(o);
  endtask

  task automatic test_reset;
    logic [22:0] v;
    reset = 1'b1;
    light = G;
    #12;
    v = {phase, dwell, remaining, locked, code_err, seq_err, dur_err, cycle_done};
    checks++;
    if (v !== 23'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", v, 23'd0);
    end
    light = R;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_clean_cycle;
    ent_t e, o;
    int k = 0;
    drive_phase(R, 10, mk(R, 8'd0,  0, 0, 0, 0, 0));
    drive_phase(G, 90, mk(G, 8'd89, 1, 0, 0, 0, 0));
    drive_phase(Y, 5,  mk(Y, 8'd4,  1, 0, 0, 0, 0));
    drive_phase(R, 30, mk(R, 8'd29, 1, 0, 0, 0, 1));
    drive_phase(G, 90, mk(G, 8'd89, 1, 0, 0, 0, 0));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL clean_cycle entry%0d got=%h exp=%h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_long_green;
    ent_t e, o;
    int k = 0;
    drive_phase(Y, 5,  mk(Y, 8'd4,  1, 0, 0, 0, 0));
    drive_phase(R, 30, mk(R, 8'd29, 1, 0, 0, 0, 1));
    drive_phase(G, 95, mk(G, 8'd89, 1, 0, 0, 0, 0));
    drive_phase(Y, 5,  mk(Y, 8'd4,  1, 0, 0, 1, 0));
    drive_phase(R, 30, mk(R, 8'd29, 1, 0, 0, 0, 0));
    drive_phase(G, 90, mk(G, 8'd89, 1, 0, 0, 0, 0));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL long_green entry%0d got=%h exp=%h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_skip_green;
    ent_t e, o;
    int k = 0;
    drive_phase(Y, 5,  mk(Y, 8'd4,  1, 0, 0, 0, 0));
    drive_phase(R, 30, mk(R, 8'd29, 1, 0, 0, 0, 1));
    drive_phase(Y, 5,  mk(Y, 8'd4,  1, 0, 1, 0, 0));
    drive_phase(R, 30, mk(R, 8'd29, 1, 0, 0, 0, 0));
    drive_phase(G, 90, mk(G, 8'd89, 1, 0, 0, 0, 0));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL skip_green entry%0d got=%h exp=%h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_illegal_code;
    ent_t e, o;
    int k = 0;
    drive_phase(Y, 5,  mk(Y, 8'd4,  1, 0, 0, 0, 0));
    drive_phase(R, 30, mk(R, 8'd29, 1, 0, 0, 0, 1));
    drive_phase(G, 40, mk(G, 8'd89, 1, 0, 0, 0, 0));
    drive_phase(X, 3,  mk(X, 8'd0,  0, 1, 0, 0, 0));
    drive_phase(R, 30, mk(R, 8'd0,  0, 0, 0, 0, 0));
    drive_phase(G, 90, mk(G, 8'd89, 1, 0, 0, 0, 0));
    drive_phase(Y, 5,  mk(Y, 8'd4,  1, 0, 0, 0, 0));
    drive_phase(R, 30, mk(R, 8'd29, 1, 0, 0, 0, 1));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL illegal_code entry%0d got=%h exp=%h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_mid_reset;
    ent_t e, o;
    logic [22:0] v;
    int k = 0;
    drive_phase(G, 40, mk(G, 8'd89, 1, 0, 0, 0, 0));
    checks++;
    if (dwell !== 8'd40) begin failures++; $display("FAIL pre_reset_dwell got=%0d exp=40", dwell); end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    v = {phase, dwell, remaining, locked, code_err, seq_err, dur_err, cycle_done};
    checks++;
    if (v !== 23'd0) begin failures++; $display("FAIL mid_reset got=%h exp=%h", v, 23'd0); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_phase(G, 90, mk(G, 8'd89, 1, 0, 0, 0, 0));
    drive_phase(Y, 5,  mk(Y, 8'd4,  1, 0, 0, 0, 0));
    drive_phase(R, 30, mk(R, 8'd29, 1, 0, 0, 0, 1));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL mid_reset_relock entry%0d got=%h exp=%h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_saturation;
    ent_t e, o;
    int k = 0;
    int pulses = 0;
    int at = 0;
    @(negedge clk);
    light = G;
    for (int i = 1; i <= 260; i++) begin
      @(posedge clk);
      #1;
      if (dur_err === 1'b1) begin pulses++; at = i; end
    end
    checks++;
    if (pulses !== 1 || at !== 255) begin
      failures++; $display("FAIL sat_pulse got=%0d_at_%0d exp=1_at_255", pulses, at);
    end
    checks++;
    if (dwell !== 8'd255) begin failures++; $display("FAIL sat_dwell got=%0d exp=255", dwell); end
    drive_phase(Y, 5,  mk(Y, 8'd4,  1, 0, 0, 1, 0));
    drive_phase(R, 30, mk(R, 8'd29, 1, 0, 0, 0, 0));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL saturation entry%0d got=%h exp=%h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_sticky;
    ent_t e, o;
    int k = 0;
    drive_phase(R, 10, mk(R, 8'd0,  0, 0, 0, 0, 0));
    drive_phase(G, 90, mk(G, 8'd89, 1, 0, 0, 0, 0));
    drive_phase(Y, 5,  mk(Y, 8'd4,  1, 0, 0, 0, 0));
    drive_phase(R, 30, mk(R, 8'd29, 1, 0, 0, 0, 1));
    drive_phase(G, 95, mk(G, 8'd89, 1, 0, 0, 0, 0));
    drive_phase(Y, 5,  mk(Y, 8'd4,  1, 0, 0, 1, 0));
    drive_phase(R, 30, mk(R, 8'd29, 1, 0, 0, 1, 0));
    drive_phase(G, 90, mk(G, 8'd89, 1, 0, 0, 1, 0));
    drive_phase(Y, 5,  mk(Y, 8'd4,  1, 0, 0, 1, 0));
    drive_phase(R, 30, mk(R, 8'd29, 1, 0, 0, 1, 0));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL sticky entry%0d got=%h exp=%h", k, o, e); end
      k++;
    end
  endtask

  initial begin
    test_reset();
`ifdef TLM_STICKY_ERR_EN
    test_sticky();
`else
    test_clean_cycle();
    test_long_green();
    test_skip_green();
    test_illegal_code();
    test_mid_reset();
    test_saturation();
`endif
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d/%0d exp=0/0", exp_q.size(), obs_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
